// File: rtl/tl_arbiter_rr4_pkg.sv
// Shared definitions for the transaction-layer round-robin arbiter:
// requester count, word/class field geometry and FSM encodings.
package tl_arbiter_rr4_pkg;

    localparam int NUM_REQ   = 4;
    localparam int REQ_W     = 2;
    localparam int TL_DATA_W = 10;
    // Destination class occupies the top CLS_W bits of each word.
    localparam int CLS_W     = 2;
    // Wide enough for BURST_LEN up to 15.
    localparam int BCNT_W    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // One-hot to index; returns 0 for an all-zero vector.
    function automatic logic [REQ_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [REQ_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = REQ_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick4.sv
// Rotating-priority picker: first set bit of elig_i starting at ptr_i,
// wrapping 3 -> 0. Purely combinational.
module rr_prio_pick4
    import tl_arbiter_rr4_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [REQ_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    logic [REQ_W-1:0] idx;

    // Walk the requesters from ptr_i; the 2-bit index wraps naturally.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_i + REQ_W'(k);
            if (!valid_o && elig_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_arbiter_rr4.sv
// Four-way round-robin arbiter with bounded bursts between the VC input
// FIFOs and the destination FIFOs. Pop is combinational in the grant
// cycle; push/data_out follow one clock later.
module tl_arbiter_rr4
    import tl_arbiter_rr4_pkg::*;
#(
    parameter int DATA_W    = TL_DATA_W,
    parameter int BURST_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [3:0]        almost_full,
    output logic [3:0]        pop,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out,
    output logic              idle
);

    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

    logic [NUM_REQ-1:0][DATA_W-1:0] din;
    logic [NUM_REQ-1:0][CLS_W-1:0]  dest;
    logic [NUM_REQ-1:0]             elig;

    arb_state_e          fsm_q, fsm_d;
    logic [REQ_W-1:0]    ptr_q, ptr_d;
    logic [REQ_W-1:0]    cur_q, cur_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]          push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                idle_q, idle_d;

    logic                keep_cur;
    logic [NUM_REQ-1:0]  pick_elig;
    logic [REQ_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  grant;
    logic                gnt_vld;
    logic [REQ_W-1:0]    gidx;

    assign din = {data_in3, data_in2, data_in1, data_in0};

    // Destination class and eligibility of each head word.
    always_comb begin
        dest = '0;
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dest[i] = din[i][DATA_W-1 -: CLS_W];
            elig[i] = state & ~empty[i] & ~almost_full[dest[i]];
        end
    end

    // Picker setup: leaving a burst searches the others from cur+1.
    always_comb begin
        keep_cur  = (fsm_q == ST_BURST) && (cnt_q < BURST_MAX) && elig[cur_q];
        pick_ptr  = ptr_q;
        pick_elig = elig;
        if (fsm_q == ST_BURST) begin
            pick_ptr  = cur_q + 2'd1;
            pick_elig = elig & ~(4'b0001 << cur_q);
        end
    end

    rr_prio_pick4 u_pick (
        .elig_i  (pick_elig),
        .ptr_i   (pick_ptr),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    // Next-state: burst continuation, burst exit with pointer advance, or fresh pick.
    always_comb begin
        fsm_d   = fsm_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        grant   = '0;
        gnt_vld = 1'b0;
        gidx    = cur_q;
        if (!state) begin
            // Hold: no grants, drop ownership but keep the pointer.
            fsm_d = ST_IDLE;
        end else if (keep_cur) begin
            grant   = 4'b0001 << cur_q;
            gnt_vld = 1'b1;
            cnt_d   = cnt_q + 4'd1;
        end else begin
            if (fsm_q == ST_BURST) ptr_d = pick_ptr;
            if (pick_valid) begin
                grant   = pick_grant;
                gnt_vld = 1'b1;
                gidx    = oh2idx(pick_grant);
                cur_d   = gidx;
                cnt_d   = 4'd1;
                fsm_d   = ST_BURST;
            end else begin
                fsm_d = ST_IDLE;
            end
        end
    end

    // Registered forward path: push one-hot on destination class, hold data otherwise.
    always_comb begin
        push_d = gnt_vld ? (4'b0001 << dest[gidx]) : 4'b0000;
        data_d = gnt_vld ? din[gidx] : data_q;
        idle_d = (&empty) & ~gnt_vld;
    end

    // State and output registers; reset discards any pending push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q  <= ST_IDLE;
            ptr_q  <= '0;
            cur_q  <= '0;
            cnt_q  <= '0;
            push_q <= '0;
            data_q <= '0;
            idle_q <= 1'b1;
        end else begin
            fsm_q  <= fsm_d;
            ptr_q  <= ptr_d;
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            push_q <= push_d;
            data_q <= data_d;
            idle_q <= idle_d;
        end
    end

    assign pop      = reset ? 4'b0000 : grant;
    assign push     = push_q;
    assign data_out = data_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_tl_arbiter_rr4.sv
// Directed bench: two arbiter instances (BURST_LEN 2 and 1) share stimulus;
// each table row names which instance it checks.
module tb_tl_arbiter_rr4;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          state;
    logic [3:0]    empty, almost_full;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    pop2, push2, pop1, push1;
    logic [DW-1:0] dout2, dout1;
    logic          idle2, idle1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tl_arbiter_rr4 #(.DATA_W(DW), .BURST_LEN(2)) dut (
        .clk(clk), .reset(reset), .state(state), .empty(empty),
        .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .almost_full(almost_full), .pop(pop2), .push(push2),
        .data_out(dout2), .idle(idle2)
    );

    tl_arbiter_rr4 #(.DATA_W(DW), .BURST_LEN(1)) dut_rr (
        .clk(clk), .reset(reset), .state(state), .empty(empty),
        .data_in0(d0), .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .almost_full(almost_full), .pop(pop1), .push(push1),
        .data_out(dout1), .idle(idle1)
    );

    typedef struct packed {
        logic              b1;   // 1: check the BURST_LEN=1 instance
        logic              rb;   // pulse reset before this row
        logic              st;
        logic [3:0]        emp;
        logic [3:0][DW-1:0] d;
        logic [3:0]        af;
        logic [3:0]        pop;
        logic [3:0]        push;
        logic [DW-1:0]     data;
        logic              idle;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic b1, input logic rb, input logic st,
                                input logic [3:0] emp,
                                input logic [DW-1:0] x3, input logic [DW-1:0] x2,
                                input logic [DW-1:0] x1, input logic [DW-1:0] x0,
                                input logic [3:0] af, input logic [3:0] p,
                                input logic [3:0] ps, input logic [DW-1:0] dt,
                                input logic id);
        vec_t v;
        v.b1 = b1; v.rb = rb; v.st = st; v.emp = emp;
        v.d = {x3, x2, x1, x0};
        v.af = af; v.pop = p; v.push = ps; v.data = dt; v.idle = id;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; state = 1'b0; empty = 4'hF; almost_full = 4'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int row);
        if (v.rb) do_reset();
        @(negedge clk);
        state = v.st; empty = v.emp; almost_full = v.af;
        d0 = v.d[0]; d1 = v.d[1]; d2 = v.d[2]; d3 = v.d[3];
        #1;
        chk("pop", row, 16'(v.b1 ? pop1 : pop2), 16'(v.pop));
        @(posedge clk);
        #1;
        chk("push", row, 16'(v.b1 ? push1 : push2), 16'(v.push));
        chk("data_out", row, 16'(v.b1 ? dout1 : dout2), 16'(v.data));
        chk("idle", row, 16'(v.b1 ? idle1 : idle2), 16'(v.idle));
    endtask

    initial begin
        // Plain round robin on the BURST_LEN=1 instance, all class 0.
        vt.push_back(mk(1,1,1,4'b0000,10'h044,10'h033,10'h022,10'h011,4'b0000,4'b0001,4'b0001,10'h011,0));
        vt.push_back(mk(1,0,1,4'b0000,10'h044,10'h033,10'h022,10'h011,4'b0000,4'b0010,4'b0001,10'h022,0));
        vt.push_back(mk(1,0,1,4'b0000,10'h044,10'h033,10'h022,10'h011,4'b0000,4'b0100,4'b0001,10'h033,0));
        vt.push_back(mk(1,0,1,4'b0000,10'h044,10'h033,10'h022,10'h011,4'b0000,4'b1000,4'b0001,10'h044,0));
        vt.push_back(mk(1,0,1,4'b0000,10'h044,10'h033,10'h022,10'h011,4'b0000,4'b0001,4'b0001,10'h011,0));
        // Bursts of two between queues 0 and 2; heads advance as popped.
        vt.push_back(mk(0,1,1,4'b1010,10'h000,10'h031,10'h000,10'h001,4'b0000,4'b0001,4'b0001,10'h001,0));
        vt.push_back(mk(0,0,1,4'b1010,10'h000,10'h031,10'h000,10'h002,4'b0000,4'b0001,4'b0001,10'h002,0));
        vt.push_back(mk(0,0,1,4'b1010,10'h000,10'h031,10'h000,10'h003,4'b0000,4'b0100,4'b0001,10'h031,0));
        vt.push_back(mk(0,0,1,4'b1010,10'h000,10'h032,10'h000,10'h003,4'b0000,4'b0100,4'b0001,10'h032,0));
        vt.push_back(mk(0,0,1,4'b1010,10'h000,10'h033,10'h000,10'h003,4'b0000,4'b0001,4'b0001,10'h003,0));
        vt.push_back(mk(0,0,1,4'b1010,10'h000,10'h033,10'h000,10'h004,4'b0000,4'b0001,4'b0001,10'h004,0));
        // Backpressure on class 2 blocks queue 1; queue 3 served instead.
        vt.push_back(mk(0,1,1,4'b0101,10'h0C3,10'h000,10'h2A5,10'h000,4'b0100,4'b1000,4'b0001,10'h0C3,0));
        vt.push_back(mk(0,0,1,4'b0101,10'h0C4,10'h000,10'h2A5,10'h000,4'b0100,4'b1000,4'b0001,10'h0C4,0));
        vt.push_back(mk(0,0,1,4'b1101,10'h0C4,10'h000,10'h2A5,10'h000,4'b0100,4'b0000,4'b0000,10'h0C4,0));
        vt.push_back(mk(0,0,1,4'b1101,10'h0C4,10'h000,10'h2A5,10'h000,4'b0000,4'b0010,4'b0100,10'h2A5,0));
        vt.push_back(mk(0,0,1,4'b1111,10'h0C4,10'h000,10'h2A5,10'h000,4'b0000,4'b0000,4'b0000,10'h2A5,1));
        // Single word on queue 3, then empty: back to IDLE, idle asserted.
        vt.push_back(mk(0,1,1,4'b0111,10'h1B7,10'h000,10'h000,10'h000,4'b0000,4'b1000,4'b0010,10'h1B7,0));
        vt.push_back(mk(0,0,1,4'b1111,10'h1B7,10'h000,10'h000,10'h000,4'b0000,4'b0000,4'b0000,10'h1B7,1));
        vt.push_back(mk(0,0,1,4'b0110,10'h0D8,10'h000,10'h000,10'h012,4'b0000,4'b0001,4'b0001,10'h012,0));
        // state falling mid-burst: pending push lands, then nothing.
        vt.push_back(mk(0,1,1,4'b0000,10'h044,10'h033,10'h022,10'h141,4'b0000,4'b0001,4'b0010,10'h141,0));
        vt.push_back(mk(0,0,0,4'b0000,10'h044,10'h033,10'h022,10'h141,4'b0000,4'b0000,4'b0000,10'h141,0));
        vt.push_back(mk(0,0,1,4'b0000,10'h044,10'h033,10'h022,10'h141,4'b0000,4'b0001,4'b0010,10'h141,0));
        // almost_full rises on the owner's class: pointer advances past it.
        vt.push_back(mk(0,1,1,4'b1110,10'h000,10'h000,10'h022,10'h301,4'b0000,4'b0001,4'b1000,10'h301,0));
        vt.push_back(mk(0,0,1,4'b1110,10'h000,10'h000,10'h022,10'h301,4'b1000,4'b0000,4'b0000,10'h301,0));
        vt.push_back(mk(0,0,1,4'b1100,10'h000,10'h000,10'h022,10'h301,4'b0000,4'b0010,4'b0001,10'h022,0));
        // Lead-in for async reset: q2 bursts, then q3 takes over (ptr=3).
        vt.push_back(mk(0,1,1,4'b1011,10'h077,10'h066,10'h022,10'h011,4'b0000,4'b0100,4'b0001,10'h066,0));
        vt.push_back(mk(0,0,1,4'b0000,10'h077,10'h067,10'h022,10'h011,4'b0000,4'b0100,4'b0001,10'h067,0));
        vt.push_back(mk(0,0,1,4'b0000,10'h077,10'h068,10'h022,10'h011,4'b0000,4'b1000,4'b0001,10'h077,0));

        // Reset state and hold.
        reset = 1'b1; state = 1'b0; empty = 4'h0; almost_full = 4'h0;
        d0 = 10'h011; d1 = 10'h022; d2 = 10'h033; d3 = 10'h044;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", 0, 16'(pop2), 16'h0);
        chk("rst_pop_rr", 0, 16'(pop1), 16'h0);
        chk("rst_push", 0, 16'(push2), 16'h0);
        chk("rst_data", 0, 16'(dout2), 16'h0);
        chk("rst_idle", 0, 16'(idle2), 16'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("hold_pop", 0, 16'(pop2), 16'h0);
        @(posedge clk);
        #1;
        chk("hold_push", 0, 16'(push2), 16'h0);
        chk("hold_data", 0, 16'(dout2), 16'h0);
        chk("hold_idle", 0, 16'(idle2), 16'h0);

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i + 1);

        // Async reset mid-burst: outputs clear before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pop", 100, 16'(pop2), 16'h0);
        chk("arst_push", 100, 16'(push2), 16'h0);
        chk("arst_data", 100, 16'(dout2), 16'h0);
        chk("arst_idle", 100, 16'(idle2), 16'h1);
        @(negedge clk);
        reset = 1'b0; state = 1'b1; empty = 4'b0000; almost_full = 4'h0;
        #1;
        chk("arst_restart_pop", 101, 16'(pop2), 16'b0001);
        @(posedge clk);
        #1;
        chk("arst_restart_push", 101, 16'(push2), 16'b0001);
        chk("arst_restart_data", 101, 16'(dout2), 16'(10'h011));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
